// File: rtl/ctrl_pipe.sv
// Generic control-signal pipeline: STAGES registered stages carrying a WIDTH-bit
// control bundle with per-stage valid, field mask, stall, flush and bubble insertion.
module ctrl_pipe #(
    parameter int unsigned               WIDTH     = 16,
    parameter int unsigned               STAGES    = 3,
    parameter logic [STAGES*WIDTH-1:0]   KEEP_MASK = '1,
    parameter int unsigned               CNTW      = 16
) (
    input  logic                             clk,
    input  logic                             R,
    input  logic [WIDTH-1:0]                 in_ctrl,
    input  logic                             in_valid,
    input  logic                             S,
    input  logic                             LE,
    input  logic [STAGES-1:0]                stall,
    input  logic [STAGES-1:0]                flush,
    input  logic                             clr_cnt,
    output logic                             in_ready,
    output logic [STAGES*WIDTH-1:0]          out_ctrl,
    output logic [STAGES-1:0]                out_valid,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic [CNTW-1:0]                  stall_cnt
);

    localparam int unsigned OCCW = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  ctrl_q  [STAGES];
    logic [WIDTH-1:0]  ctrl_d  [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] hold;

    // A stall in stage k holds every stage at or below k.
    always_comb begin
        hold = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            hold[k] = !LE || (|(stall >> k));
        end
    end

    assign in_ready = !hold[0];

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (LE && flush[0]) begin
            ctrl_d[0]  = '0;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            if (in_valid && !S) begin
                ctrl_d[0]  = in_ctrl & KEEP_MASK[0 +: WIDTH];
                valid_d[0] = 1'b1;
            end else begin
                ctrl_d[0]  = '0;
                valid_d[0] = 1'b0;
            end
        end

        // A moving stage behind a held one receives a bubble rather than a duplicate.
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (LE && flush[k]) begin
                ctrl_d[k]  = '0;
                valid_d[k] = 1'b0;
            end else if (!hold[k]) begin
                if (hold[k-1]) begin
                    ctrl_d[k]  = '0;
                    valid_d[k] = 1'b0;
                end else begin
                    ctrl_d[k]  = ctrl_q[k-1] & KEEP_MASK[k*WIDTH +: WIDTH];
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (LE && (|stall) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        out_ctrl = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            out_ctrl[k*WIDTH +: WIDTH] = ctrl_q[k];
        end
    end

    assign out_valid = valid_q;

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCCW'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a 3-stage pipe with stage-2 mask 0x00FF and
// a 2-bit-counter instance sharing the same stimulus.
module tb_ctrl_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned N = 3;

    logic          clk;
    logic          R;
    logic [W-1:0]  in_ctrl;
    logic          in_valid;
    logic          S;
    logic          LE;
    logic [N-1:0]  stall;
    logic [N-1:0]  flush;
    logic          clr_cnt;

    logic          in_ready;
    logic [N*W-1:0] out_ctrl;
    logic [N-1:0]  out_valid;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          sat_ready;
    logic [N*W-1:0] sat_ctrl;
    logic [N-1:0]  sat_valid;
    logic [1:0]    sat_occ;
    logic [1:0]    sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_pipe #(
        .WIDTH     (W),
        .STAGES    (N),
        .KEEP_MASK ({16'h00FF, 16'hFFFF, 16'hFFFF}),
        .CNTW      (16)
    ) dut (
        .clk       (clk),
        .R         (R),
        .in_ctrl   (in_ctrl),
        .in_valid  (in_valid),
        .S         (S),
        .LE        (LE),
        .stall     (stall),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .in_ready  (in_ready),
        .out_ctrl  (out_ctrl),
        .out_valid (out_valid),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    ctrl_pipe #(
        .WIDTH  (W),
        .STAGES (N),
        .CNTW   (2)
    ) dut_sat (
        .clk       (clk),
        .R         (R),
        .in_ctrl   (in_ctrl),
        .in_valid  (in_valid),
        .S         (S),
        .LE        (LE),
        .stall     (stall),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .in_ready  (sat_ready),
        .out_ctrl  (sat_ctrl),
        .out_valid (sat_valid),
        .occupancy (sat_occ),
        .stall_cnt (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        R        = 1'b0;
        in_ctrl  = '0;
        in_valid = 1'b0;
        S        = 1'b0;
        LE       = 1'b1;
        stall    = '0;
        flush    = '0;
        clr_cnt  = 1'b0;
        #2;
        check("rst_valid", out_valid, 3'b000);
        check("rst_ctrl",  out_ctrl, 48'h0);
        check("rst_cnt",   stall_cnt, 16'd0);
        check("rst_occ",   occupancy, 2'd0);
        check("rst_ready", in_ready, 1'b1);
        #6 R = 1'b1;

        // Fill and drain
        in_valid = 1'b1; in_ctrl = 16'h0001; step();
        check("fill1_occ", occupancy, 2'd1);
        in_ctrl = 16'h0002; step();
        check("fill2_occ", occupancy, 2'd2);
        in_ctrl = 16'h0003; step();
        check("fill3_ctrl", out_ctrl, 48'h0001_0002_0003);
        check("fill3_occ",  occupancy, 2'd3);
        in_valid = 1'b0; in_ctrl = 16'h0000; step();
        check("drain1_ctrl", out_ctrl, 48'h0002_0003_0000);
        check("drain1_occ",  occupancy, 2'd2);
        step();
        check("drain2_ctrl", out_ctrl, 48'h0003_0000_0000);
        check("drain2_occ",  occupancy, 2'd1);
        step();
        check("drain3_occ",  occupancy, 2'd0);

        // Mask in stage 2
        in_valid = 1'b1; in_ctrl = 16'hABCD; step();
        in_valid = 1'b0; step();
        check("mask_s1", out_ctrl, 48'h0000_ABCD_0000);
        step();
        check("mask_s2", out_ctrl, 48'h00CD_0000_0000);

        // Stall in stage 1 with the pipe full
        in_valid = 1'b1;
        in_ctrl = 16'h0011; step();
        in_ctrl = 16'h0022; step();
        in_ctrl = 16'h0033; step();
        check("full_valid", out_valid, 3'b111);
        stall = 3'b010; in_ctrl = 16'h0044; #1;
        check("stall_ready", in_ready, 1'b0);
        step();
        check("stall1_valid", out_valid, 3'b011);
        check("stall1_cnt",   stall_cnt, 16'd1);
        step();
        check("stall2_ctrl",  out_ctrl, 48'h0000_0022_0033);
        check("stall2_valid", out_valid, 3'b011);
        check("stall2_cnt",   stall_cnt, 16'd2);
        check("stall2_ready", in_ready, 1'b0);
        stall = 3'b000; #1;
        check("unstall_ready", in_ready, 1'b1);
        step();
        check("resume_ctrl",  out_ctrl, 48'h0022_0033_0044);
        check("resume_valid", out_valid, 3'b111);

        // Flush and stall on stage 1 together
        stall = 3'b010; flush = 3'b010; in_ctrl = 16'h0055; step();
        check("flush_ctrl",  out_ctrl, 48'h0000_0000_0044);
        check("flush_valid", out_valid, 3'b001);
        check("flush_cnt",   stall_cnt, 16'd3);
        check("flush_sat",   sat_cnt, 2'd3);
        stall = 3'b000; flush = 3'b000;

        // LE=0 freezes everything, flush ignored
        LE = 1'b0; stall = 3'b001; flush = 3'b100; in_ctrl = 16'h0066; #1;
        check("le0_ready", in_ready, 1'b0);
        step(); step(); step();
        check("le0_ctrl",  out_ctrl, 48'h0000_0000_0044);
        check("le0_valid", out_valid, 3'b001);
        check("le0_cnt",   stall_cnt, 16'd3);
        clr_cnt = 1'b1; step();
        check("clr_le0_cnt", stall_cnt, 16'd0);
        clr_cnt = 1'b0; LE = 1'b1; stall = 3'b000; flush = 3'b000;

        // Bubble select
        S = 1'b1; in_ctrl = 16'h0077; step();
        check("bubble_ctrl",  out_ctrl, 48'h0000_0044_0000);
        check("bubble_valid", out_valid, 3'b010);
        S = 1'b0; in_ctrl = 16'h0088; step();
        check("s0_load_ctrl", out_ctrl, 48'h0044_0000_0088);
        S = 1'b1; stall = 3'b001; step();
        check("s_stall_ctrl",  out_ctrl, 48'h0000_0000_0088);
        check("s_stall_valid", out_valid, 3'b001);
        check("s_stall_cnt",   stall_cnt, 16'd1);
        S = 1'b0;

        // Saturation of the 2-bit counter over 5 stall cycles
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt",  sat_cnt, 2'd3);
        check("wide_cnt", stall_cnt, 16'd6);
        stall = 3'b000;

        // Asynchronous reset with the pipe full
        in_valid = 1'b1;
        in_ctrl = 16'h0101; step();
        in_ctrl = 16'h0202; step();
        in_ctrl = 16'h0303; step();
        check("prerst_valid", out_valid, 3'b111);
        #2 R = 1'b0;
        #1;
        check("arst_valid", out_valid, 3'b000);
        check("arst_ctrl",  out_ctrl, 48'h0);
        check("arst_occ",   occupancy, 2'd0);
        check("arst_cnt",   stall_cnt, 16'd0);
        check("arst_sat",   sat_cnt, 2'd0);
        #2 R = 1'b1;
        in_ctrl = 16'h0404; step();
        check("post_rst_ctrl",  out_ctrl, 48'h0000_0000_0404);
        check("post_rst_valid", out_valid, 3'b001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline that replaces the fixed ID/EX, EX/MEM and MEM/WB control registers and the bubble mux with a single generic block. It carries a WIDTH-bit control bundle through STAGES registered stages. Each stage has a valid bit, a per-stage field mask, stall, flush and bubble insertion. A saturating stall-cycle counter supports hazard profiling. It sits between the Control Unit output and the execute/memory/write-back datapath.

## Interface
- WIDTH, 16: control bundle width in bits.
- STAGES, 3: number of pipeline stages (≥1).
- KEEP_MASK, all ones (STAGES*WIDTH bits): slice k = fields retained in stage k; cleared bits are forced to 0.
- CNTW, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- R  in  1  reset, asynchronous, active-low.
- in_ctrl  in  WIDTH  control bundle from the Control Unit.
- in_valid  in  1  in_ctrl holds a real instruction.
- S  in  1  bubble select; 1 replaces the stage-0 input with a bubble.
- LE  in  1  global load enable; 0 freezes every stage and the counter.
- stall  in  STAGES  per-stage hold request.
- flush  in  STAGES  per-stage kill request.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- in_ready  out  1  stage 0 accepts this cycle.
- out_ctrl  out  STAGES*WIDTH  slice k = stage-k register.
- out_valid  out  STAGES  valid bit per stage.
- occupancy  out  clog2(STAGES+1)  number of set out_valid bits (combinational popcount).
- stall_cnt  out  CNTW  cycles with any stall asserted while LE=1.

## Operation
- Bubble: ctrl = 0 and valid = 0.
- Hold: h_k = !LE or (OR of stall[j] for j ≥ k). A stall in stage k holds stages 0..k.
- Stage 0 next value:
  - in_ctrl & mask_0 with valid = 1 when in_valid=1 and S=0;
  - otherwise a bubble.
- Stage k>0 next value: stage k-1 contents & mask_k.
  - If h_{k-1}=1 and h_k=0, stage k loads a bubble instead.
- Held stage: keeps its contents and valid bit.
- Flush priority: flush[k]=1 with LE=1 loads a bubble into stage k, even when h_k=1.
  - Flush does not affect the hold of other stages.
  - With LE=0, flush is ignored.
- Last stage: drains every cycle unless h_{STAGES-1}=1. There is no downstream backpressure.
- in_ready = !h_0.
  - When in_ready=0, in_ctrl is not consumed; the source must hold it.
- stall_cnt:
  - +1 on each edge with LE=1 and |stall=1;
  - saturates at 2^CNTW-1;
  - clr_cnt has priority over increment and clears even when LE=0.

## Timing
- Reset (R=0, asynchronous): out_ctrl=0, out_valid=0, stall_cnt=0, occupancy=0. in_ready follows its combinational equation.
- Release of R: the first edge with R=1 behaves as a normal cycle.
- Latency: a bundle accepted at edge t appears on stage 0 after t and on stage k after edge t+k, with no stalls.
- Mid-operation reset: all stages are cleared immediately, without waiting for clk.
- Simultaneous events:
  - flush and stall on the same stage: flush wins (stage becomes a bubble) and the stages below stay held;
  - S=1 and stall[0]=1: stage 0 holds (stall wins), and the bubble is not inserted.
- Arithmetic: masking is a bitwise AND; occupancy is unsigned; stall_cnt does not wrap.

## Test plan
- Fill/drain: STAGES=3, stream in_ctrl = 0x0001, 0x0002, 0x0003 with in_valid=1 → stage 2 shows 0x0001, 0x0002, 0x0003 on cycles 3, 4, 5. occupancy rises 1→3, then falls to 0 after in_valid drops.
- Stall bubble: stall[1]=1 for 2 cycles with the pipe full → stages 0 and 1 hold, stage 2 receives 2 bubbles (out_valid[2]=0), in_ready=0, stall_cnt=2.
- Flush vs stall: stall[1]=1 and flush[1]=1 in the same cycle → stage 1 becomes a bubble, stage 0 holds its value, stage 2 gets a bubble.
- Mask: KEEP_MASK slice 2 = 0x00FF, in_ctrl=0xABCD → stage 1 = 0xABCD, stage 2 = 0x00CD.
- LE/S/saturation:
  - LE=0 for 3 cycles with stall[0]=1 → no state change, stall_cnt unchanged;
  - S=1 → stage 0 bubble;
  - CNTW=2 with 5 stall cycles → stall_cnt=3.
- Async reset: assert R=0 between clock edges with the pipe full → all outputs 0 before the next edge; after release, the first accepted bundle reaches stage 0 in 1 cycle.
